// File: rtl/pid_pkg.sv
// pid_pkg: scheduler state encodings and the clog2 helper used for channel index width
package pid_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_SEND} state_t;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/pid_chan_sched_if.sv
// pid_chan_sched_if: scheduler<->pid_core bus; master=scheduler (issues samples), slave=core (returns results)
interface pid_chan_sched_if #(
  parameter int W_IN  = 18,
  parameter int W_OUT = 32,
  parameter int W_CH  = 3
);
  logic [W_IN-1:0]  pid_data_out;
  logic             pid_valid_out;
  logic [W_CH-1:0]  pid_chan_out;
  logic [W_OUT-1:0] pid_data_in;
  logic             pid_valid_in;
  modport master(output pid_data_out, pid_valid_out, pid_chan_out, input pid_data_in, pid_valid_in);
  modport slave(input pid_data_out, pid_valid_out, pid_chan_out, output pid_data_in, pid_valid_in);
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first set req_i after ptr_i (wrapping); grant_o index, any_o when any request
module rr_arbiter #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic [W-1:0] grant_o,
  output logic         any_o
);
  logic [W-1:0] idx;
  always_comb begin
    grant_o = '0;
    idx = '0;
    for (int i = N; i >= 1; i--) begin
      idx = W'((int'(ptr_i) + i) % N);
      if (req_i[idx]) grant_o = idx;
    end
    any_o = |req_i;
  end
endmodule

// File: rtl/pid_chan_sched.sv
// pid_chan_sched: round-robin share of one pid_core among N_CHAN channels; ch_* in, core bus via interface, tagged result/ovr/timeout out
module pid_chan_sched
  import pid_pkg::*;
#(
  parameter int N_CHAN  = 8,
  parameter int W_CH    = clog2(N_CHAN),
  parameter int W_IN    = 18,
  parameter int W_OUT   = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                   clk_in,
  input  logic                   reset_in,
  input  logic [N_CHAN*W_IN-1:0] ch_data_in,
  input  logic [N_CHAN-1:0]      ch_valid_in,
  input  logic [N_CHAN-1:0]      chan_en_in,
  input  logic                   clear_ovr_in,
  pid_chan_sched_if.master       core,
  output logic [W_OUT-1:0]       data_out,
  output logic [W_CH-1:0]        chan_out,
  output logic                   data_valid_out,
  output logic [N_CHAN-1:0]      ovr_out,
  output logic                   timeout_out
);
  localparam int W_CNT = clog2(TIMEOUT);
  state_t                       state_q;
  logic [N_CHAN-1:0][W_IN-1:0] sbuf_q, sbuf_d;
  logic [N_CHAN-1:0]            pend_q, pend_d, ovr_q, ovr_d, hit;
  logic [W_CH-1:0]              ptr_q, grant_q, arb_grant;
  logic [W_OUT-1:0]             res_q;
  logic [W_CNT-1:0]             cnt_q;
  logic                         arb_any, expire;
  rr_arbiter #(.N(N_CHAN), .W(W_CH)) u_arb (
    .req_i  (pend_q & chan_en_in),
    .ptr_i  (ptr_q),
    .grant_o(arb_grant),
    .any_o  (arb_any)
  );
  // the channel being issued this cycle gets its pend cleared; a fresh strobe in the same cycle re-arms it without an overrun
  assign hit = (state_q == ST_ISSUE) ? N_CHAN'(1) << grant_q : '0;
  assign expire = (state_q == ST_WAIT) && (cnt_q == W_CNT'(TIMEOUT - 1)) && !core.pid_valid_in;
  always_comb begin
    pend_d = pend_q;
    ovr_d = clear_ovr_in ? '0 : ovr_q;
    sbuf_d = sbuf_q;
    for (int k = 0; k < N_CHAN; k++) begin
      if (!chan_en_in[k]) pend_d[k] = 1'b0;
      else if (ch_valid_in[k]) begin
        sbuf_d[k] = ch_data_in[k*W_IN +: W_IN];
        pend_d[k] = 1'b1;
        if (pend_q[k] && !hit[k]) ovr_d[k] = 1'b1;
      end else if (hit[k]) pend_d[k] = 1'b0;
    end
  end
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q <= ST_IDLE;
      sbuf_q <= '0;
      pend_q <= '0;
      ovr_q <= '0;
      ptr_q <= W_CH'(N_CHAN - 1);
      grant_q <= '0;
      res_q <= '0;
      cnt_q <= '0;
    end else begin
      sbuf_q <= sbuf_d;
      pend_q <= pend_d;
      ovr_q <= ovr_d;
      case (state_q)
        ST_IDLE: if (arb_any) begin
          grant_q <= arb_grant;
          state_q <= ST_ISSUE;
        end
        ST_ISSUE: begin
          ptr_q <= grant_q;
          cnt_q <= '0;
          state_q <= ST_WAIT;
        end
        ST_WAIT: if (core.pid_valid_in) begin
          res_q <= core.pid_data_in;
          state_q <= ST_SEND;
        end else if (expire) state_q <= ST_IDLE;
        else cnt_q <= cnt_q + 1'b1;
        default: state_q <= ST_IDLE;
      endcase
    end
  end
  assign core.pid_valid_out = state_q == ST_ISSUE;
  assign core.pid_data_out = core.pid_valid_out ? sbuf_q[grant_q] : '0;
  assign core.pid_chan_out = grant_q;
  assign data_out = res_q;
  assign chan_out = grant_q;
  assign data_valid_out = state_q == ST_SEND;
  assign ovr_out = ovr_q;
  assign timeout_out = expire;
endmodule

// File: tb/tb_pid_chan_sched.sv
// tb_pid_chan_sched: directed stimulus with a cycle-stamped scoreboard for issues, results and timeouts
module tb_pid_chan_sched;
  typedef struct {int cyc; int ch; logic [31:0] dat;} ev_t;
  logic clk = 0, rst, clear_ovr;
  logic [143:0] ch_data;
  logic [7:0] ch_valid, chan_en, ovr_out;
  logic [31:0] data_out;
  logic [2:0] chan_out;
  logic data_valid_out, timeout_out, rsp_on;
  logic [31:0] rsp_tab [8];
  int rsp_dly, cyc = 0, checks = 0, errors = 0, t;
  ev_t iq[$], rq[$];
  int tq[$];
  pid_chan_sched_if #(.W_IN(18), .W_OUT(32), .W_CH(3)) cif ();
  pid_chan_sched dut (
    .clk_in(clk), .reset_in(rst), .ch_data_in(ch_data), .ch_valid_in(ch_valid),
    .chan_en_in(chan_en), .clear_ovr_in(clear_ovr), .core(cif),
    .data_out(data_out), .chan_out(chan_out), .data_valid_out(data_valid_out),
    .ovr_out(ovr_out), .timeout_out(timeout_out)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask
  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic setd(int k, logic [17:0] v);
    ch_data[k*18 +: 18] = v;
  endtask
  task automatic chk_zero(string name);
    chk({name, "_core"}, {cif.pid_valid_out, cif.pid_data_out, cif.pid_chan_out}, 0);
    chk({name, "_out"}, {data_out, chan_out, data_valid_out, ovr_out, timeout_out}, 0);
  endtask
  task automatic exp_iss(int c, int ch, logic [31:0] d);
    iq.push_back('{c, ch, d});
  endtask
  task automatic exp_res(int c, int ch, logic [31:0] d);
    rq.push_back('{c, ch, d});
  endtask
  // core model: answers rsp_dly cycles after each issue with the per-channel table value
  initial begin
    cif.pid_valid_in = 0;
    cif.pid_data_in = 0;
    forever begin
      @(negedge clk);
      if (cif.pid_valid_out && rsp_on) begin
        automatic int ch = int'(cif.pid_chan_out);
        repeat (rsp_dly) @(posedge clk);
        #1 cif.pid_valid_in = 1;
        cif.pid_data_in = rsp_tab[ch];
        @(posedge clk);
        #1 cif.pid_valid_in = 0;
      end
    end
  end
  always @(negedge clk) begin
    ev_t e;
    if (cif.pid_valid_out) begin
      if (iq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_issue act=ch%0d@%0d exp=none", cif.pid_chan_out, cyc);
      end else begin
        e = iq.pop_front();
        chk("issue_cyc", cyc, e.cyc);
        chk("issue_ch", cif.pid_chan_out, e.ch);
        chk("issue_data", cif.pid_data_out, e.dat);
      end
    end
    if (data_valid_out) begin
      if (rq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_result act=ch%0d@%0d exp=none", chan_out, cyc);
      end else begin
        e = rq.pop_front();
        chk("result_cyc", cyc, e.cyc);
        chk("result_ch", chan_out, e.ch);
        chk("result_data", data_out, e.dat);
      end
    end
    if (timeout_out) begin
      if (tq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_timeout act=%0d exp=none", cyc);
      end else chk("timeout_cyc", cyc, tq.pop_front());
    end
  end
  initial begin
    rst = 1; ch_valid = 0; ch_data = 0; chan_en = '1; clear_ovr = 0; rsp_on = 1; rsp_dly = 2;
    for (int k = 0; k < 8; k++) rsp_tab[k] = 0;
    tick(3);
    chk_zero("reset");
    rst = 0;
    tick(2);
    // two full bursts: order 0..7, then restart at 0 after ptr=7
    for (int b = 0; b < 2; b++) begin
      t = cyc;
      for (int k = 0; k < 8; k++) begin
        setd(k, 18'(32 * b + 16 + k));
        rsp_tab[k] = 32'hA000 + 32'(b * 4096 + k);
        exp_iss(t + 2 + 5 * k, k, 32'(32 * b + 16 + k));
        exp_res(t + 5 + 5 * k, k, 32'hA000 + 32'(b * 4096 + k));
      end
      ch_valid = '1; tick(1); ch_valid = 0;
      tick(45);
    end
    // single sample, 5 cycles strobe-to-result
    setd(2, 18'h00100); rsp_tab[2] = 32'h1234; t = cyc;
    exp_iss(t + 2, 2, 32'h100); exp_res(t + 5, 2, 32'h1234);
    ch_valid = 8'h04; tick(1); ch_valid = 0;
    tick(10);
    // overrun: second strobe before grant overwrites and flags
    setd(3, 18'd5); rsp_tab[3] = 32'h3333; t = cyc;
    exp_iss(t + 2, 3, 32'd9); exp_res(t + 5, 3, 32'h3333);
    ch_valid = 8'h08; tick(1); setd(3, 18'd9); tick(1); ch_valid = 0;
    tick(8);
    chk("ovr_set", ovr_out, 8'h08);
    clear_ovr = 1; tick(1); clear_ovr = 0;
    chk("ovr_clear", ovr_out, 8'h00);
    // strobe during its own ISSUE cycle re-arms without overrun
    setd(6, 18'h66); rsp_tab[6] = 32'h6666; t = cyc;
    exp_iss(t + 2, 6, 32'h66); exp_res(t + 5, 6, 32'h6666);
    exp_iss(t + 7, 6, 32'h67); exp_res(t + 10, 6, 32'h6666);
    ch_valid = 8'h40; tick(1); ch_valid = 0; tick(1);
    setd(6, 18'h67); ch_valid = 8'h40; tick(1); ch_valid = 0;
    tick(12);
    chk("ovr_issue_cycle", ovr_out, 8'h00);
    // timeout on ch1, ch5 still issues two cycles later
    rsp_on = 0; setd(1, 18'h11); setd(5, 18'h55); rsp_tab[5] = 32'h5555; t = cyc;
    exp_iss(t + 2, 1, 32'h11); tq.push_back(t + 18);
    exp_iss(t + 20, 5, 32'h55); exp_res(t + 23, 5, 32'h5555);
    ch_valid = 8'h22; tick(1); ch_valid = 0;
    tick(17);
    rsp_on = 1;
    tick(12);
    // disabled ch1 is dropped and stays un-pended after re-enable
    chan_en = 8'hFD; setd(1, 18'h12); setd(4, 18'h44); rsp_tab[4] = 32'h4444; t = cyc;
    exp_iss(t + 2, 4, 32'h44); exp_res(t + 5, 4, 32'h4444);
    ch_valid = 8'h12; tick(1); ch_valid = 0;
    tick(8);
    chan_en = '1;
    tick(10);
    chk("ovr_after_disabled", ovr_out, 8'h00);
    // reset during WAIT discards in-flight and pending samples; late response ignored
    rsp_dly = 4; setd(5, 18'h5A); setd(6, 18'h6B); rsp_tab[5] = 32'h5A5A; t = cyc;
    exp_iss(t + 2, 5, 32'h5A);
    ch_valid = 8'h60; tick(1); ch_valid = 0;
    tick(3);
    rst = 1; tick(1);
    chk_zero("reset_mid");
    rst = 0; tick(2);
    chk_zero("late_rsp");
    tick(4);
    rsp_dly = 2;
    setd(0, 18'h0C0); setd(7, 18'h0C7); rsp_tab[0] = 32'hC0; rsp_tab[7] = 32'hC7; t = cyc;
    exp_iss(t + 2, 0, 32'h0C0); exp_res(t + 5, 0, 32'hC0);
    exp_iss(t + 7, 7, 32'h0C7); exp_res(t + 10, 7, 32'hC7);
    ch_valid = 8'h81; tick(1); ch_valid = 0;
    tick(15);
    chk("issues_left", iq.size(), 0);
    chk("results_left", rq.size(), 0);
    chk("timeouts_left", tq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
